// File: rtl/riscv_pkg.sv
// Constants shared by the fetch and decode stages.
//   INSN_WIDTH : instruction word width
//   HALT_INSN  : word that stops the fetch stage (decode recognises the same value)
//   PC_STEP    : byte increment between consecutive instruction words
package riscv_pkg;

    localparam int          INSN_WIDTH = 32;
    localparam logic [31:0] HALT_INSN  = 32'hFFFF_FFFF;
    localparam int          PC_STEP    = 4;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO buffering {pc, instruction} entries between the memory
// response path and decode.
//   clk, rst     : clock, synchronous active-high reset
//   push/pop     : enqueue push_data / dequeue the head entry
//   flush        : empty the queue; overrides push and pop in the same cycle
//   head_data    : oldest entry (don't-care while empty)
//   count        : number of valid entries
//   empty, full  : occupancy flags
module fetch_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        push_data,
    output logic [DATA_WIDTH-1:0]        head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full queue can still accept when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to a
// pipelined in-order instruction memory, queues returned words with their PC
// and hands them to decode over valid/ready. Redirects flush the queue and
// discard stale in-flight responses; fetching stops after the halt word.
//   clk, rst                          : clock, synchronous active-high reset
//   imem_req_valid/addr/ready         : fetch request channel
//   imem_resp_valid/data              : in-order response channel, no back-pressure
//   redirect_valid/pc                 : control-flow redirect from execute
//   id_valid/ready/instruction/pc     : decode handshake
//   halted                            : halt word fetched, requests stopped
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    output logic [WIDTH-1:0]      imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [INSN_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [WIDTH-1:0]      redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [INSN_WIDTH-1:0] id_instruction,
    output logic [WIDTH-1:0]      id_pc,
    output logic                  halted
);

    localparam int               CNT_W   = $clog2(2 * QUEUE_DEPTH + 1);
    localparam int               QCNT_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int               ENTRY_W = WIDTH + INSN_WIDTH;
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(PC_STEP);
    localparam logic [CNT_W:0]   CREDITS = (CNT_W + 1)'(QUEUE_DEPTH);

    logic [WIDTH-1:0]   pc;
    logic [WIDTH-1:0]   resp_pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   outstanding_after_resp;
    logic [CNT_W-1:0]   drop;
    logic [CNT_W-1:0]   live;
    logic [CNT_W:0]     in_use;
    logic [QCNT_W-1:0]  q_count;
    logic               q_empty;
    logic               q_full;
    logic               q_push;
    logic               q_pop;
    logic [ENTRY_W-1:0] q_head;
    logic               req_fire;
    logic               resp_live;

    // Credits come from registered state only, so a pop this cycle is not
    // reusable until the next one; this keeps the request path short.
    assign live           = outstanding - drop;
    assign in_use         = {1'b0, live} + (CNT_W + 1)'(q_count);
    assign imem_req_valid = !rst && !redirect_valid && !halted && (in_use < CREDITS);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_live = imem_resp_valid && (drop == '0) && !redirect_valid;
    assign q_push    = resp_live && !q_full;
    assign q_pop     = !q_empty && id_ready && !redirect_valid;

    assign id_valid                  = !q_empty;
    assign {id_pc, id_instruction}   = q_head;

    // Saturate so a response with nothing outstanding (e.g. left over from
    // before a reset) cannot wrap the counter and starve the credit check.
    assign outstanding_after_resp = (imem_resp_valid && outstanding != '0)
                                  ? outstanding - CNT_W'(1) : outstanding;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            halted      <= 1'b0;
        end else begin
            outstanding <= outstanding_after_resp + CNT_W'(req_fire);

            // Everything still in flight after this cycle's response is stale.
            if (redirect_valid)                      drop <= outstanding_after_resp;
            else if (imem_resp_valid && drop != '0)  drop <= drop - CNT_W'(1);

            if (redirect_valid) begin
                pc      <= redirect_pc;
                resp_pc <= redirect_pc;
                halted  <= 1'b0;
            end else begin
                if (req_fire)  pc      <= pc + STEP;
                if (resp_live) resp_pc <= resp_pc + STEP;
                if (resp_live && imem_resp_data == HALT_INSN) halted <= 1'b1;
            end
        end
    end

    fetch_queue #(
        .DATA_WIDTH (ENTRY_W),
        .DEPTH      (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .push_data ({resp_pc, imem_resp_data}),
        .head_data (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import riscv_pkg::*;

    localparam int W  = 32;
    localparam int QD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic          redirect_valid, id_valid, id_ready, halted;
    logic [W-1:0]  imem_req_addr, redirect_pc, id_pc;
    logic [31:0]   imem_resp_data, id_instruction;

    logic          w_req_valid, w_id_valid, w_halted;
    logic [W-1:0]  w_req_addr, w_id_pc;
    logic [31:0]   w_id_instruction;

    instruction_fetch #(.WIDTH(W), .RESET_PC('0), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instruction(id_instruction), .id_pc(id_pc),
        .halted(halted)
    );

    // Second instance only to observe PC wrap-around from the top of the space.
    instruction_fetch #(.WIDTH(W), .RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(QD)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(w_id_valid), .id_ready(id_ready), .id_instruction(w_id_instruction), .id_pc(w_id_pc),
        .halted(w_halted)
    );

    typedef struct { logic [W-1:0] pc; logic [31:0] insn; } exp_t;
    typedef struct { logic [31:0] data; int due; int epoch; } mem_t;
    typedef struct { int lat; int pre; logic [W-1:0] target; logic [W-1:0] exp_pc; logic [31:0] exp_insn; } redir_vec_t;

    exp_t exp_q[$];
    mem_t pend[$];

    int checks = 0, errors = 0;
    int cyc = 0, epoch = 0, last_due = 0, n_arrived = 0, mem_lat = 1, pop_count = 0;
    logic [W-1:0] exp_addr = '0;
    logic         exp_halted = 1'b0;
    logic         halt_en = 1'b0;
    logic [W-1:0] halt_addr = '0;
    logic [W-1:0] last_pop_pc = '0;
    logic [31:0]  last_pop_insn = '0;
    logic [W-1:0] halt_pop_pc = '1;

    logic         t_rst, t_req_ready, t_id_ready, t_redir;
    logic [W-1:0] t_redir_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [W-1:0] a);
        if (halt_en && a == halt_addr) return HALT_INSN;
        return {a[23:0], 8'h13};
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare settled
    // outputs against the reference model, then advance the model.
    task automatic step();
        logic resp_live, exp_req, popping;
        mem_t m;
        @(negedge clk);
        rst            = t_rst;
        imem_req_ready = t_req_ready;
        id_ready       = t_id_ready;
        redirect_valid = t_redir;
        redirect_pc    = t_redir_pc;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        resp_live       = 1'b0;
        if (!t_rst && pend.size() > 0 && pend[0].due <= cyc) begin
            m = pend.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = m.data;
            resp_live       = (m.epoch == epoch) && !t_redir;
        end
        #1;
        exp_req = !t_rst && !t_redir && !exp_halted && (exp_q.size() < QD);
        popping = !t_rst && !t_redir && (n_arrived != 0) && t_id_ready;
        check("req_valid", imem_req_valid, exp_req);
        if (!t_rst) check("req_addr", imem_req_addr, exp_addr);
        check("id_valid", id_valid, n_arrived != 0);
        check("halted", halted, exp_halted);
        if (popping) begin
            check("id_pc", id_pc, exp_q[0].pc);
            check("id_insn", id_instruction, exp_q[0].insn);
            last_pop_pc   = id_pc;
            last_pop_insn = id_instruction;
            if (id_instruction == HALT_INSN) halt_pop_pc = id_pc;
        end

        if (t_rst) begin
            exp_q.delete();
            pend.delete();
            n_arrived  = 0;
            exp_addr   = '0;
            exp_halted = 1'b0;
            last_due   = 0;
            epoch++;
        end else begin
            if (popping) begin
                void'(exp_q.pop_front());
                n_arrived--;
                pop_count++;
            end
            if (resp_live) begin
                n_arrived++;
                if (m.data == HALT_INSN) exp_halted = 1'b1;
            end
            if (t_redir) begin
                exp_q.delete();
                n_arrived  = 0;
                exp_halted = 1'b0;
                exp_addr   = t_redir_pc;
                epoch++;
            end else if (exp_req && t_req_ready) begin
                exp_q.push_back('{exp_addr, mem_data(exp_addr)});
                last_due = (cyc + mem_lat > last_due) ? cyc + mem_lat : last_due + 1;
                pend.push_back('{mem_data(imem_req_addr), last_due, epoch});
                exp_addr = exp_addr + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic wait_pop(input string name, input logic [W-1:0] pc_req);
        int base;
        base = pop_count;
        for (int k = 0; k < 30 && pop_count == base; k++) step();
        check({name, "_arrived"}, pop_count != base, 1'b1);
        check({name, "_pc"}, last_pop_pc, pc_req);
    endtask

    task automatic redirect_to(input logic [W-1:0] target);
        t_redir = 1'b1; t_redir_pc = target;
        step();
        t_redir = 1'b0;
        step();
        check("flush_empty", id_valid, 1'b0);
    endtask

    redir_vec_t vecs[4];

    initial begin
        int found;
        int base;
        vecs[0] = '{3, 2, 32'h0000_0100, 32'h0000_0100, 32'h0001_0013};
        vecs[1] = '{1, 3, 32'h0000_0040, 32'h0000_0040, 32'h0000_4013};
        vecs[2] = '{2, 4, 32'h0000_1000, 32'h0000_1000, 32'h0010_0013};
        vecs[3] = '{1, 1, 32'h0000_003C, 32'h0000_003C, 32'h0000_3C13};

        rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        t_rst = 1'b1; t_req_ready = 1'b1; t_id_ready = 1'b1; t_redir = 1'b0; t_redir_pc = '0;

        // Reset and streaming
        step(); step();
        check("reset_addr", imem_req_addr, 32'h0);
        check("reset_id_valid", id_valid, 1'b0);
        t_rst = 1'b0;
        step();
        check("first_req_valid", imem_req_valid, 1'b1);
        check("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_second_addr", w_req_addr, 32'h0);
        base = pop_count;
        repeat (12) step();
        check("stream_progress", (pop_count - base) >= 6, 1'b1);

        // Decode back-pressure
        t_id_ready = 1'b0;
        repeat (5) step();
        check("bp_req_blocked", imem_req_valid, 1'b0);
        check("bp_head_held", id_valid, 1'b1);
        t_id_ready = 1'b1;
        repeat (6) step();

        // Memory stall: request address must hold
        t_req_ready = 1'b0;
        repeat (4) step();
        t_req_ready = 1'b1;
        repeat (4) step();

        // Table of redirects with fetches in flight at various latencies
        for (int i = 0; i < 4; i++) begin
            mem_lat = vecs[i].lat;
            repeat (vecs[i].pre) step();
            redirect_to(vecs[i].target);
            wait_pop("redir_vec", vecs[i].exp_pc);
            check("redir_vec_insn", last_pop_insn, vecs[i].exp_insn);
        end

        // Redirect in the same cycle as a response
        mem_lat = 2;
        repeat (3) step();
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (pend.size() > 0 && pend[0].due <= cyc) found = 1;
            else step();
        end
        check("coincide_setup", found, 1);
        redirect_to(32'h200);
        wait_pop("coincide", 32'h200);
        repeat (5) step();

        // Halt word at 0x8, then resume via redirect
        t_rst = 1'b1; step(); t_rst = 1'b0;
        halt_en = 1'b1; halt_addr = 32'h8; mem_lat = 1;
        for (int k = 0; k < 30 && !halted; k++) step();
        check("halt_reached", halted, 1'b1);
        repeat (8) step();
        check("halt_word_pc", halt_pop_pc, 32'h8);
        check("halt_no_req", imem_req_valid, 1'b0);
        halt_en = 1'b0;
        redirect_to(32'h20);
        check("halt_cleared", halted, 1'b0);
        wait_pop("resume", 32'h20);
        repeat (4) step();

        // Reset in the middle of traffic
        mem_lat = 2; t_id_ready = 1'b0;
        repeat (3) step();
        t_rst = 1'b1; step(); t_rst = 1'b0; t_id_ready = 1'b1;
        step();
        check("midreset_id_valid", id_valid, 1'b0);
        wait_pop("midreset", 32'h0);
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
